fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the main decoder/control logic. It owns the PC register and issues one instruction-memory read at a time over a valid/ready request plus valid response interface. It presents the fetched instruction, its PC and PC+4 to decode, which supplies op/func3/func7. On consumption it advances the PC using the core's pc_source selection (PC+4 or branch/jump target).

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and boot constants.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request channel plus a valid-only response channel.
interface fetch_unit_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read at a time and holds the fetched
// instruction for decode until it is consumed, then steps or redirects the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        o_instr,
    output logic [31:0]        o_instr_pc,
    output logic [31:0]        o_instr_pc_plus4,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    input  logic               i_pc_source,
    input  logic [31:0]        i_pc_target,
    output logic               o_fetch_misaligned
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_misaligned;

    logic [31:0] w_pc_next;
    logic        w_next_aligned;
    logic        w_latch;
    logic        w_consume;

    assign w_pc_next      = i_pc_source ? i_pc_target : (r_pc + 32'd4);
    assign w_next_aligned = is_word_aligned(w_pc_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        imem.req_valid = 1'b0;
        o_instr_valid  = 1'b0;
        w_latch        = 1'b0;
        w_consume      = 1'b0;
        case (r_state)
            IDLE: w_state_next = REQ;
            REQ: begin
                imem.req_valid = 1'b1;
                if (imem.req_ready) w_state_next = WAIT;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    w_latch      = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                o_instr_valid = 1'b1;
                if (i_instr_ready) begin
                    w_consume    = 1'b1;
                    w_state_next = w_next_aligned ? REQ : HALT;
                end
            end
            HALT: w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    // A misaligned redirect freezes the PC at the offending instruction for post-mortem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_instr      <= NOP_INSTR;
            r_instr_pc   <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            if (w_latch) begin
                r_instr    <= imem.rsp_data;
                r_instr_pc <= r_pc;
            end
            if (w_consume) begin
                if (w_next_aligned) r_pc <= w_pc_next;
                else                r_misaligned <= 1'b1;
            end
        end
    end

    assign imem.req_addr        = r_pc;
    assign o_instr              = r_instr;
    assign o_instr_pc           = r_instr_pc;
    assign o_instr_pc_plus4     = r_instr_pc + 32'd4;
    assign o_fetch_misaligned   = r_misaligned;

endmodule
